snn_step_scheduler: RTL and testbench

SNN_STEP_SCHEDULER -- requirements
Module: snn_step_scheduler

---
 rtl/snn_sched_pkg.sv | 26 ++
 rtl/snn_spike_counter_bank.sv | 46 ++++
 rtl/snn_step_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_snn_step_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// snn_sched_pkg : state type and default sizing for the SNN step scheduler
// Rev 1.0
// -----------------------------------------------------------------------------
package snn_sched_pkg;

  localparam int C_N_IN  = 16;
  localparam int C_N_OUT = 8;
  localparam int C_CNT_W = 8;
  localparam int C_LAT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int win_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snn_spike_counter_bank.sv
`default_nettype none
// -----------------------------------------------------------------------------
// snn_spike_counter_bank : N_OUT saturating spike counters, clear has priority
// Rev 1.0
// -----------------------------------------------------------------------------
module snn_spike_counter_bank
  import snn_sched_pkg::*;
#(
  parameter int N_OUT = C_N_OUT,
  parameter int CNT_W = C_CNT_W
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   clr_i,
  input  logic                   inc_en_i,
  input  logic [N_OUT-1:0]       spk_i,
  output logic [N_OUT*CNT_W-1:0] cnt_o,
  output logic [N_OUT*CNT_W-1:0] cnt_next_o
);

  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_en_i && spk_i[g] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!resetb) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_o[g*CNT_W +: CNT_W]      = cnt_q;
    assign cnt_next_o[g*CNT_W +: CNT_W] = cnt_d;
  end : g_cnt

endmodule
`default_nettype wire

// File: rtl/snn_step_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// snn_step_scheduler : sequences timesteps into snn_network and tallies spikes.
// Define SNN_SCHED_WINNER_EN to build the argmax winner; otherwise winner = 0.
// Rev 1.0
// -----------------------------------------------------------------------------
module snn_step_scheduler
  import snn_sched_pkg::*;
#(
  parameter int N_IN    = C_N_IN,
  parameter int N_OUT   = C_N_OUT,
  parameter int CNT_W   = C_CNT_W,
  parameter int NET_LAT = 1
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic [7:0]                 cfg_steps,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_vec,
  output logic [N_IN-1:0]            net_in,
  output logic                       net_step,
  output logic                       net_clr,
  input  logic [N_OUT-1:0]           net_out_spk,
  output logic                       busy,
  output logic                       done,
  output logic [N_OUT*CNT_W-1:0]     spike_cnt,
  output logic [win_w(N_OUT)-1:0]    winner
);

  localparam int                 WIN_W = win_w(N_OUT);
  localparam logic [C_LAT_W-1:0] LAT_C = C_LAT_W'(NET_LAT);

  state_e               state_q, state_d;
  logic [7:0]           steps_q, steps_d;
  logic [7:0]           step_q, step_d;
  logic [7:0]           step_inc;
  logic [C_LAT_W-1:0]   lat_q, lat_d;
  logic [N_IN-1:0]      net_in_q, net_in_d;
  logic                 net_step_q, net_step_d;
  logic                 net_clr_q, net_clr_d;
  logic                 cnt_clr, cnt_inc;
  logic [N_OUT*CNT_W-1:0] cnt, cnt_next;

  assign step_inc = step_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    steps_d    = steps_q;
    step_d     = step_q;
    lat_d      = lat_q;
    net_in_d   = net_in_q;
    net_step_d = 1'b0;
    net_clr_d  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          steps_d = cfg_steps;
          if (cfg_steps == 8'd0) begin
            state_d = ST_DONE;
            cnt_clr = 1'b1;
          end else begin
            state_d   = ST_CLEAR;
            net_clr_d = 1'b1;
            net_in_d  = '0;
          end
        end
      end
      ST_CLEAR: begin
        cnt_clr = 1'b1;
        step_d  = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (in_valid) begin
          net_in_d   = in_vec;
          net_step_d = 1'b1;
          lat_d      = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // lat_q counts from the net_step cycle; output is valid NET_LAT later
        if (lat_q == LAT_C) begin
          cnt_inc = 1'b1;
          step_d  = step_inc;
          state_d = (step_inc == steps_q) ? ST_DONE : ST_FEED;
        end else begin
          lat_d = lat_q + C_LAT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      net_clr_d  = 1'b1;
      net_step_d = 1'b0;
      net_in_d   = '0;
      cnt_clr    = 1'b1;
      cnt_inc    = 1'b0;
      step_d     = '0;
      lat_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      steps_q    <= '0;
      step_q     <= '0;
      lat_q      <= '0;
      net_in_q   <= '0;
      net_step_q <= 1'b0;
      net_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      steps_q    <= steps_d;
      step_q     <= step_d;
      lat_q      <= lat_d;
      net_in_q   <= net_in_d;
      net_step_q <= net_step_d;
      net_clr_q  <= net_clr_d;
    end
  end

  snn_spike_counter_bank #(
    .N_OUT (N_OUT),
    .CNT_W (CNT_W)
  ) u_cnt_bank (
    .clk        (clk),
    .resetb     (resetb),
    .clr_i      (cnt_clr),
    .inc_en_i   (cnt_inc),
    .spk_i      (net_out_spk),
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next)
  );

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_FEED) && !abort;
  assign done      = (state_q == ST_DONE) && !abort;
  assign net_in    = net_in_q;
  assign net_step  = net_step_q;
  assign net_clr   = net_clr_q;
  assign spike_cnt = cnt;

`ifdef SNN_SCHED_WINNER_EN
  logic [WIN_W-1:0] winner_q, winner_d, argmax;
  logic [CNT_W-1:0] best;

  // Strict compare keeps the lowest index on ties; looks at the post-update
  // counts so winner is valid in the same cycle as done.
  always_comb begin
    argmax = '0;
    best   = cnt_next[CNT_W-1:0];
    for (int i = 1; i < N_OUT; i++) begin
      if (cnt_next[i*CNT_W +: CNT_W] > best) begin
        best   = cnt_next[i*CNT_W +: CNT_W];
        argmax = WIN_W'(i);
      end
    end
  end

  always_comb begin
    winner_d = winner_q;
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      winner_d = argmax;
    end else if (cnt_clr) begin
      winner_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      winner_q <= '0;
    end else begin
      winner_q <= winner_d;
    end
  end

  assign winner = winner_q;
`else
  logic unused_cnt_next;
  assign unused_cnt_next = ^cnt_next;
  assign winner          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_step_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_snn_step_scheduler : scoreboard bench with a one-cycle-latency network model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_snn_step_scheduler;

`ifdef SNN_SCHED_WINNER_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] cnt;
    logic [2:0]  win;
  } exp_t;

  logic        clk       = 1'b0;
  logic        resetb    = 1'b0;
  logic        start     = 1'b0;
  logic        abort     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [7:0]  cfg_steps = '0;
  logic [15:0] in_vec    = '0;
  logic [7:0]  spk_pat   = '0;
  logic [7:0]  net_out_spk;
  logic        in_ready, net_step, net_clr, busy, done;
  logic [15:0] net_in;
  logic [63:0] spike_cnt;
  logic [2:0]  winner;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;
  int   n_step = 0;
  int   n_clr  = 0;

  snn_step_scheduler dut (
    .clk         (clk),
    .resetb      (resetb),
    .cfg_steps   (cfg_steps),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .net_in      (net_in),
    .net_step    (net_step),
    .net_clr     (net_clr),
    .net_out_spk (net_out_spk),
    .busy        (busy),
    .done        (done),
    .spike_cnt   (spike_cnt),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  // Network model: spikes appear one cycle after net_step, for one cycle only
  initial net_out_spk = '0;
  always @(posedge clk) net_out_spk <= net_step ? spk_pat : 8'h00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a result
  always @(negedge clk) begin
    if (net_step) n_step++;
    if (net_clr)  n_clr++;
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        fail("unexpected_done");
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_spike_cnt", spike_cnt, mon_e.cnt);
        chk("result_winner", 64'(winner), 64'(mon_e.win));
      end
    end
  end

  task automatic push_exp(input logic [63:0] c, input logic [2:0] w);
    exp_t e;
    e.cnt = c;
    e.win = WIN_EN ? w : 3'd0;
    exp_q.push_back(e);
  endtask

  task automatic start_inf(input logic [7:0] s);
    cfg_steps = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_ready();
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail("in_ready_timeout");
  endtask

  task automatic feed(input logic [15:0] v);
    in_vec   = v;
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (n_done != d0) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (!got) fail("done_timeout");
  endtask

  task automatic run(input logic [7:0] s, input logic [15:0] v, input logic [7:0] pat,
                     input logic [63:0] ecnt, input logic [2:0] ewin);
    int d0 = n_done;
    int s0 = n_step;
    spk_pat = pat;
    push_exp(ecnt, ewin);
    start_inf(s);
    for (int i = 0; i < int'(s); i++) feed(v);
    wait_done(d0);
    chk("run_done_count", 64'(n_done - d0), 64'd1);
    chk("run_step_count", 64'(n_step - s0), 64'(s));
  endtask

  initial begin
    int d0, s0, c0;

    // Reset values
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_net_step",  64'(net_step),  64'd0);
    chk("rst_net_clr",   64'(net_clr),   64'd0);
    chk("rst_net_in",    64'(net_in),    64'd0);
    chk("rst_spike_cnt", spike_cnt,      64'd0);
    chk("rst_winner",    64'(winner),    64'd0);
    @(posedge clk); #1;
    resetb = 1'b1;

    // Three steps, neuron 2 fires every step
    run(8'd3, 16'h0001, 8'h04, 64'h0000_0000_0003_0000, 3'd2);
    chk("net_in_hold", 64'(net_in), 64'h0001);

    // Four steps with in_valid withheld before step 2; a start while busy is ignored
    d0 = n_done; s0 = n_step;
    spk_pat = 8'h81;
    push_exp(64'h0400_0000_0000_0004, 3'd0);
    start_inf(8'd4);
    feed(16'h00F0);
    cfg_steps = 8'd1;
    start     = 1'b1;
    wait_ready();
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    chk("stall_no_step", 64'(n_step - s0), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    feed(16'h0F00);
    feed(16'hF000);
    feed(16'h000F);
    wait_done(d0);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_step_count", 64'(n_step - s0), 64'd4);
    chk("stall_done_count", 64'(n_done - d0), 64'd1);

    // Zero steps: done one cycle after start, counts cleared, no net_step
    d0 = n_done; s0 = n_step;
    push_exp(64'd0, 3'd0);
    start_inf(8'd0);
    @(negedge clk);
    chk("zero_steps_done", 64'(done), 64'd1);
    wait_done(d0);
    @(negedge clk);
    chk("zero_steps_done_width", 64'(done), 64'd0);
    chk("zero_steps_no_step", 64'(n_step - s0), 64'd0);
    @(posedge clk); #1;

    // 255 steps, every neuron fires: all counts at maximum, tie resolves to 0
    run(8'd255, 16'hFFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);

    // Abort in WAIT of step 2 of 5
    d0 = n_done; s0 = n_step; c0 = n_clr;
    spk_pat = 8'h10;
    start_inf(8'd5);
    feed(16'h0003);
    feed(16'h0005);
    chk("abort_pre_cnt", spike_cnt, 64'h0000_0001_0000_0000);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy",      64'(busy),    64'd0);
    chk("abort_net_clr",   64'(net_clr), 64'd1);
    chk("abort_spike_cnt", spike_cnt,    64'd0);
    chk("abort_net_in",    64'(net_in),  64'd0);
    @(negedge clk);
    chk("abort_net_clr_width", 64'(net_clr), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done",   64'(n_done - d0), 64'd0);
    chk("abort_clr_count", 64'(n_clr - c0),  64'd2);
    chk("abort_steps",     64'(n_step - s0), 64'd2);

    // Reset for one cycle during FEED, then a normal inference
    d0 = n_done;
    spk_pat = 8'h0A;
    start_inf(8'd3);
    feed(16'h1234);
    wait_ready();
    resetb = 1'b0;
    @(posedge clk); #1;
    resetb = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",      64'(busy),     64'd0);
    chk("mid_rst_done",      64'(done),     64'd0);
    chk("mid_rst_in_ready",  64'(in_ready), 64'd0);
    chk("mid_rst_net_step",  64'(net_step), 64'd0);
    chk("mid_rst_net_clr",   64'(net_clr),  64'd0);
    chk("mid_rst_net_in",    64'(net_in),   64'd0);
    chk("mid_rst_spike_cnt", spike_cnt,     64'd0);
    chk("mid_rst_winner",    64'(winner),   64'd0);
    chk("mid_rst_no_done",   64'(n_done - d0), 64'd0);
    @(posedge clk); #1;
    run(8'd2, 16'hBEEF, 8'h0A, 64'h0000_0000_0200_0200, 3'd1);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
